reciprocal_arbiter: RTL

//  Shares one pipelined reciprocal unit (16.16 fixed point, NUMERATOR/x) between NB_REQ requesters
//  (rasterizer setup, perspective-correct texture stage, ...). Round-robin grant, one issue per cycle.

---
 rtl/reciprocal_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/reciprocal_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/reciprocal_arb_pkg.sv
// Shared constants and types for the reciprocal arbiter slice.
// Used by reciprocal_arbiter and rr_arbiter.
package reciprocal_arb_pkg;

  localparam int NB_REQ_DEF = 4;
  localparam int STAT_W     = 32;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // A single requester still needs a one-bit id so the tag struct stays legal.
  function automatic int idWidth(input int nbReq);
    return (nbReq > 1) ? $clog2(nbReq) : 1;
  endfunction

  localparam int ID_W = idWidth(NB_REQ_DEF);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } recip_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above i_ptr, wrapping.
module rr_arbiter
  import reciprocal_arb_pkg::*;
#(
  parameter int NB_REQ = 4,
  parameter int ID_W   = idWidth(NB_REQ)
) (
  input  logic [ID_W-1:0]   i_ptr,
  input  logic [NB_REQ-1:0] i_eligible,
  output logic [NB_REQ-1:0] o_grant,
  output logic [ID_W-1:0]   o_grantIdx,
  output logic              o_grantValid
);

  always_comb begin
    int idx;
    idx          = 0;
    o_grant      = '0;
    o_grantIdx   = '0;
    o_grantValid = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      idx = (int'(i_ptr) + k) % NB_REQ;
      if (!o_grantValid && i_eligible[idx]) begin
        o_grantValid = 1'b1;
        o_grantIdx   = ID_W'(idx);
        o_grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reciprocal_arbiter.sv
// Shares one external pipelined reciprocal unit between NB_REQ requesters with tag-routed results.
// Optional RECIPROCAL_ARB_STATS_EN adds grant and stall counters.
module reciprocal_arbiter
  import reciprocal_arb_pkg::*;
#(
  parameter int NB_REQ        = 4,
  parameter int RECIP_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic [NB_REQ-1:0]      req_valid_i,
  input  logic [NB_REQ-1:0][31:0] req_x_i,
  output logic [NB_REQ-1:0]      req_ready_o,
  output logic [NB_REQ-1:0]      rsp_valid_o,
  output logic [NB_REQ-1:0][31:0] rsp_z_o,
  input  logic [NB_REQ-1:0]      rsp_ready_i,
  output logic [31:0]            recip_x_o,
  input  logic [31:0]            recip_z_i
`ifdef RECIPROCAL_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_grants_o,
  output logic [STAT_W-1:0]      stat_stall_o
`endif
);

  localparam int ID_W = idWidth(NB_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NB_REQ-1:0]       r_busy;
  logic [ID_W-1:0]         r_ptr;
  tag_t                    r_tag [RECIP_LATENCY];
  logic [NB_REQ-1:0]       r_rspValid;
  logic [NB_REQ-1:0][31:0] r_rspZ;

  logic [NB_REQ-1:0] w_eligible;
  logic [NB_REQ-1:0] w_grant;
  logic [ID_W-1:0]   w_grantIdx;
  logic              w_grantValid;
  logic              w_grantEn;
  logic [ID_W-1:0]   w_ptrNext;
  logic [NB_REQ-1:0] w_handshake;
  tag_t              w_lastTag;

  assign w_eligible  = req_valid_i & ~r_busy;
  assign w_handshake = r_rspValid & rsp_ready_i;
  assign w_lastTag   = r_tag[RECIP_LATENCY-1];

  rr_arbiter #(
    .NB_REQ (NB_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .i_ptr        (r_ptr),
    .i_eligible   (w_eligible),
    .o_grant      (w_grant),
    .o_grantIdx   (w_grantIdx),
    .o_grantValid (w_grantValid)
  );

  // Nothing may issue while reset is held, even though the picker itself is combinational.
  assign w_grantEn   = w_grantValid & ~reset_i;
  assign req_ready_o = reset_i ? '0 : w_grant;
  assign recip_x_o   = w_grantEn ? req_x_i[w_grantIdx] : 32'h0;
  assign w_ptrNext   = (w_grantIdx == ID_W'(NB_REQ - 1)) ? '0 : w_grantIdx + 1'b1;

  assign rsp_valid_o = r_rspValid;
  assign rsp_z_o     = r_rspZ;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_ptr <= '0;
      for (int k = 0; k < RECIP_LATENCY; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      if (w_grantEn) begin
        r_ptr <= w_ptrNext;
      end
      r_tag[0] <= '{valid: w_grantEn, id: w_grantIdx};
      for (int k = 1; k < RECIP_LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // One outstanding op per requester, so a capture never lands on a held result.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_busy     <= '0;
      r_rspValid <= '0;
      r_rspZ     <= '0;
    end else begin
      for (int i = 0; i < NB_REQ; i++) begin
        if (w_grant[i]) begin
          r_busy[i] <= 1'b1;
        end else if (w_handshake[i]) begin
          r_busy[i] <= 1'b0;
        end
        if (w_lastTag.valid && (w_lastTag.id == ID_W'(i))) begin
          r_rspValid[i] <= 1'b1;
          r_rspZ[i]     <= recip_z_i;
        end else if (w_handshake[i]) begin
          r_rspValid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef RECIPROCAL_ARB_STATS_EN
  logic [STAT_W-1:0] r_statGrants;
  logic [STAT_W-1:0] r_statStall;

  assign stat_grants_o = r_statGrants;
  assign stat_stall_o  = r_statStall;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_statGrants <= '0;
      r_statStall  <= '0;
    end else begin
      if (w_grantValid && (r_statGrants != STAT_MAX)) begin
        r_statGrants <= r_statGrants + 1'b1;
      end
      if ((|req_valid_i) && !w_grantValid && (r_statStall != STAT_MAX)) begin
        r_statStall <= r_statStall + 1'b1;
      end
    end
  end
`endif

endmodule
